// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: FSM states, opcodes, datapath mux codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_FUNC = 2'd1,
    ALU_BR   = 2'd2
  } alu_op_e;

  // Instruction class after opcode decode; CLS_NONE marks an unsupported opcode.
  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_LOAD,
    CLS_OPIMM,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JALR,
    CLS_JAL,
    CLS_LUI,
    CLS_OP
  } opc_class_e;

endpackage

// File: rtl/ctrl_opc_class.sv
// Opcode classifier: maps inst_code[6:0] to an instruction class plus a legal flag.
// Latency: purely combinational.
// Backpressure: none.
module ctrl_opc_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opc_class_e cls,
  output logic       legal
);

  // Anything outside the supported RV32I subset falls through to CLS_NONE.
  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JALR:   cls = CLS_JALR;
      OPC_JAL:    cls = CLS_JAL;
      OPC_LUI:    cls = CLS_LUI;
      OPC_OP:     cls = CLS_OP;
      default:    cls = CLS_NONE;
    endcase
  end

  assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP); optional CTRL_PERF_CNT_EN adds retire_cnt.
// Latency: BRANCH/JAL/JALR 3 cycles, ALU ops and STORE 4, LOAD 5 with zero-wait memories.
// Backpressure: imem_req/dmem_req held until ack; a wait of TIMEOUT_CYC cycles traps with bus_err.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] inst_code,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  localparam int              TO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              TO_EN   = (TIMEOUT_CYC > 0);

  state_e          state;
  opc_class_e      cls_d;
  opc_class_e      cls_q;
  logic            legal_d;
  logic [TO_W-1:0] tmo_cnt;
  logic            tmo_hit;
  logic            pc_we_q;
  pc_sel_e         pc_sel_q;
  alu_op_e         alu_op_q;
  wb_sel_e         wb_sel_q;
  logic            unused_inst;

  // Only the major opcode steers the sequencer; funct fields go straight to the ALU decoder.
  assign unused_inst = ^inst_code[31:7];

  ctrl_opc_class u_opc_class (
    .opcode (inst_code[6:0]),
    .cls    (cls_d),
    .legal  (legal_d)
  );

  // Wait counter sits at TIMEOUT_CYC-1 during the last permitted no-ack cycle.
  assign tmo_hit = TO_EN && (tmo_cnt == TO_LAST);

  // Sequencer: outputs for the next state are registered on the transition into it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      cls_q     <= CLS_NONE;
      tmo_cnt   <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      pc_we_q   <= 1'b0;
      pc_sel_q  <= PC_PLUS4;
      alu_src_b <= 1'b0;
      alu_op_q  <= ALU_ADD;
      rf_we     <= 1'b0;
      wb_sel_q  <= WB_ALU;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      pc_we_q   <= 1'b0;
      pc_sel_q  <= PC_PLUS4;
      alu_src_b <= 1'b0;
      alu_op_q  <= ALU_ADD;
      rf_we     <= 1'b0;
      wb_sel_q  <= WB_ALU;
      case (state)
        FETCH: begin
          // imem_req is low here only in the first cycle after reset release.
          if (!imem_req) begin
            imem_req <= 1'b1;
            tmo_cnt  <= '0;
          end else if (imem_ack) begin
            state <= DECODE;
          end else if (tmo_hit) begin
            bus_err <= 1'b1;
            state   <= TRAP;
          end else begin
            imem_req <= 1'b1;
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
        end
        DECODE: begin
          cls_q <= cls_d;
          if (!legal_d) begin
            illegal <= 1'b1;
            state   <= TRAP;
          end else begin
            state <= EXEC;
            case (cls_d)
              CLS_BRANCH: begin
                alu_op_q <= ALU_BR;
                pc_we_q  <= 1'b1;
              end
              CLS_JAL: begin
                rf_we    <= 1'b1;
                wb_sel_q <= WB_PC4;
                pc_we_q  <= 1'b1;
                pc_sel_q <= PC_IMM;
              end
              CLS_JALR: begin
                alu_src_b <= 1'b1;
                rf_we     <= 1'b1;
                wb_sel_q  <= WB_PC4;
                pc_we_q   <= 1'b1;
                pc_sel_q  <= PC_JALR;
              end
              CLS_OP:    alu_op_q <= ALU_FUNC;
              CLS_OPIMM: begin
                alu_op_q  <= ALU_FUNC;
                alu_src_b <= 1'b1;
              end
              CLS_LOAD, CLS_STORE: alu_src_b <= 1'b1;
              default: ;
            endcase
          end
        end
        EXEC: begin
          case (cls_q)
            CLS_OP, CLS_OPIMM, CLS_LUI: begin
              state    <= WB;
              rf_we    <= 1'b1;
              wb_sel_q <= (cls_q == CLS_LUI) ? WB_IMM : WB_ALU;
              pc_we_q  <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              state     <= MEM;
              dmem_req  <= 1'b1;
              dmem_we   <= (cls_q == CLS_STORE);
              alu_src_b <= 1'b1;
              tmo_cnt   <= '0;
            end
            default: begin
              state    <= FETCH;
              imem_req <= 1'b1;
              tmo_cnt  <= '0;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            if (cls_q == CLS_STORE) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              tmo_cnt  <= '0;
            end else begin
              state    <= WB;
              rf_we    <= 1'b1;
              wb_sel_q <= WB_MEM;
              pc_we_q  <= 1'b1;
            end
          end else if (tmo_hit) begin
            bus_err <= 1'b1;
            state   <= TRAP;
          end else begin
            dmem_req  <= 1'b1;
            dmem_we   <= dmem_we;
            alu_src_b <= 1'b1;
            tmo_cnt   <= tmo_cnt + 1'b1;
          end
        end
        WB: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          tmo_cnt  <= '0;
        end
        TRAP: ;
        default: state <= TRAP;
      endcase
    end
  end

  // Ack-qualified strobes must land in the ack cycle itself, so these few are combinational.
  assign ir_we  = imem_req & imem_ack;
  assign pc_we  = pc_we_q | (dmem_req & dmem_we & dmem_ack);
  assign pc_sel = ((state == EXEC) && (cls_q == CLS_BRANCH)) ? {1'b0, branch_taken} : pc_sel_q;
  assign alu_op = alu_op_q;
  assign wb_sel = wb_sel_q;

`ifdef CTRL_PERF_CNT_EN
  // Retired-instruction counter: one count per PC update, wrapping naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (pc_we) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end
`endif

endmodule
